uart_rx_ff: RTL and testbench
=============================

Name: uart_rx_ff

Overview:
- UART receiver; counterpart to the FIFO-fed UART transmitter.
- Oversamples the asynchronous `rx` line, recovers 8N1 frames and pushes each good byte into a downstream byte FIFO through a single-cycle write strobe.
- Sits between the board RX pin and the SoC receive FIFO. The CPU-side UART registers read that FIFO.

Parameters:
- BAUD_CYCLE, 868: bit period is BAUD_CYCLE+1 clk cycles, matching the transmitter (115200 baud at 100 MHz).
- LSB_FIRST, 1'b1: 1 = first data bit received goes to wrData[0]; 0 = first data bit goes to wrData[7].

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial input, idle high
- ffFull  in  1  downstream FIFO full
- wrEn  out  1  one-cycle write strobe into FIFO
- wrData  out  8  received byte, valid while wrEn=1
- frameErr  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: good frame dropped because ffFull=1

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - wrEn=0, frameErr=0, overrun=0, wrData=8'h00.
  - Synchronizer flops = 1; state=IDLE; counters=0.
- Input path:
  - 2-flop synchronizer on rx gives rxS, with 2-cycle latency.
  - All decisions use rxS only.
- Baud counter:
  - Counts 0..BAUD_CYCLE and cleared on every state entry.
  - HALF = (BAUD_CYCLE+1)/2, truncated.
  - Counter width is $clog2(BAUD_CYCLE+1).
- FSM states: IDLE, START, DATA, STOP, WAIT_HI.
- IDLE:
  - rxS==0 → START with counter cleared.
- START:
  - At counter==HALF-1, sample rxS.
  - rxS==1 → IDLE (glitch rejected, no output).
  - rxS==0 → DATA with counter and bit index cleared.
- DATA:
  - At counter==BAUD_CYCLE, sample rxS into the shift register, then increment the bit index.
  - Bit order follows LSB_FIRST.
  - After the 8th sample → STOP.
- STOP:
  - At counter==BAUD_CYCLE, sample rxS.
  - rxS==1 and ffFull==0: wrEn=1 for exactly the next cycle, with wrData=the assembled byte; → IDLE.
  - rxS==1 and ffFull==1: overrun=1 for one cycle, no write, byte discarded; → IDLE.
  - rxS==0: frameErr=1 for one cycle, no write; → WAIT_HI.
- WAIT_HI:
  - Stays until rxS==1, then → IDLE.
  - A break or stuck-low line never re-triggers START.
- Return to IDLE happens mid stop bit. This accepts back-to-back frames from a transmitter whose clock is up to about ±2% off.
- wrData holds its last value between strobes.
- ffFull is sampled only at the stop-bit decision cycle. The block has no backpressure elsewhere and never stalls reception.
- rst asserted mid-frame:
  - The next cycle is in IDLE with all outputs 0.
  - A partial byte is never written.
  - If rx is low at release, the block re-syncs on the next falling edge. Exception: it may start immediately if rxS is still 0, and a spurious start is rejected or framed out via frameErr/WAIT_HI.
- End-to-end latency: wrEn rises 2 + HALF + 9×(BAUD_CYCLE+1) + 1 cycles after the start edge reaches rx, ±1.

Decomposition:
- Shared package uart_pkg:
  - State enum uart_rx_state_e {IDLE, START, DATA, STOP, WAIT_HI}.
  - Constant UART_DATA_BITS=8.
  - Default BAUD_CYCLE localparam, shared with the transmitter.
- One natural sub-module: uart_sync2, a 2-flop synchronizer with reset value 1, reusable for other async inputs.
- The rest stays flat.

Test Plan:
- All scenarios use BAUD_CYCLE=15 (16 clocks/bit) and an ideal bit-accurate driver.
- Single frame 8'hA5, ffFull=0 → exactly one wrEn pulse, wrData=8'hA5, frameErr=0, overrun=0, timing within the latency bound.
- Back-to-back frames 8'h00, 8'hFF, 8'h5A with no idle gap between stop and next start → three wrEn pulses in order with correct data.
- Start-bit glitch: rx low for 4 cycles, then high → no wrEn, FSM back in IDLE, next valid frame 8'h3C received correctly.
- Frame 8'h81 with stop bit driven low, then rx held low for 100 cycles → one frameErr pulse, no wrEn, no further activity until rx returns high; following 8'h42 received.
- ffFull=1 during the stop bit of 8'h7E → one overrun pulse, no wrEn. ffFull released, next frame 8'h11 → wrEn with 8'h11.
- rst pulsed during the DATA bit 4 of a frame → outputs 0 next cycle, no wrEn for the aborted byte. The next clean frame 8'hC3 is received. LSB_FIRST=0 rerun of 8'h01 stream yields wrData=8'h80.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths: frame width,
// default baud divisor and the receiver state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  // 115200 baud at 100 MHz: bit period is UART_BAUD_CYCLE + 1 clocks.
  localparam int unsigned UART_BAUD_CYCLE = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } uart_rx_state_e;

  // Clocks from a falling start edge to the middle of the start bit.
  function automatic int unsigned uart_half_bit(input int unsigned baud_cycle);
    return (baud_cycle + 1) / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset
// to RESET_VAL so an idle-high line does not look like an edge after reset.
module uart_sync2 #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_ff.sv
// 8N1 UART receiver: oversamples rx, recovers frames and pushes good bytes into
// a downstream FIFO with a one-cycle write strobe; flags framing errors and overruns.
module uart_rx_ff
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_CYCLE = UART_BAUD_CYCLE,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rx,
  input  logic                      i_ff_full,
  output logic                      o_wr_en,
  output logic [UART_DATA_BITS-1:0] o_wr_data,
  output logic                      o_frame_err,
  output logic                      o_overrun
);

  localparam int unsigned CntW    = (BAUD_CYCLE > 0) ? $clog2(BAUD_CYCLE + 1) : 1;
  localparam int unsigned IdxW    = $clog2(UART_DATA_BITS);
  localparam int unsigned Half    = uart_half_bit(BAUD_CYCLE);
  localparam logic [CntW-1:0] CntLast = CntW'(BAUD_CYCLE);
  localparam logic [CntW-1:0] CntMid  = CntW'((Half > 0) ? Half - 1 : 0);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(UART_DATA_BITS - 1);

  uart_rx_state_e            r_state;
  logic [CntW-1:0]           r_cnt;
  logic [IdxW-1:0]           r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_wr_data;
  logic                      r_wr_en;
  logic                      r_frame_err;
  logic                      r_overrun;

  logic                      w_rx_s;
  logic                      w_cnt_last;
  logic [CntW-1:0]           w_cnt_inc;
  logic [UART_DATA_BITS-1:0] w_shift_next;

  uart_sync2 #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_async(i_rx),
    .o_sync (w_rx_s)
  );

  assign w_cnt_last = (r_cnt == CntLast);
  assign w_cnt_inc  = r_cnt + CntW'(1);

  always_comb begin
    w_shift_next = r_shift;
    if (LSB_FIRST) begin
      w_shift_next = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
    end else begin
      w_shift_next = {r_shift[UART_DATA_BITS-2:0], w_rx_s};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_wr_data   <= '0;
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (r_cnt == CntMid) begin
            // A line that is high again mid start bit was a glitch.
            r_state   <= w_rx_s ? IDLE : DATA;
            r_cnt     <= '0;
            r_bit_idx <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        DATA: begin
          if (w_cnt_last) begin
            r_cnt     <= '0;
            r_shift   <= w_shift_next;
            r_bit_idx <= r_bit_idx + IdxW'(1);
            if (r_bit_idx == IdxLast) begin
              r_state <= STOP;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        STOP: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            // Leaving mid stop bit leaves half a bit of slack for a fast sender.
            if (!w_rx_s) begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_HI;
            end else if (i_ff_full) begin
              r_overrun <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_data <= r_shift;
              r_state   <= IDLE;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        WAIT_HI: begin
          if (w_rx_s) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_wr_en     = r_wr_en;
  assign o_wr_data   = r_wr_data;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

  a_single_outcome: assert property (@(posedge i_clk) disable iff (i_rst)
    $onehot0({r_wr_en, r_frame_err, r_overrun}));

endmodule

// File: tb/tb_uart_rx_ff.sv
// Directed bench for uart_rx_ff: an LSB-first and an MSB-first receiver share one
// rx line; a frame-level event model predicts every strobe/pulse and its cycle.
module tb_uart_rx_ff;

  localparam int unsigned BaudCycle = 15;
  localparam int Bit     = BaudCycle + 1;
  localparam int Latency = 2 + Bit / 2 + 9 * Bit + 1;

  localparam logic [2:0] KWr = 3'b001;
  localparam logic [2:0] KFe = 3'b010;
  localparam logic [2:0] KOv = 3'b100;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
    logic [7:0] data;
  } ev_t;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       rx      = 1'b1;
  logic       ff_full = 1'b0;
  logic [1:0] wr_en;
  logic [1:0] frame_err;
  logic [1:0] overrun;
  logic [7:0] wr_data [2];

  int   cyc   = 0;
  logic rst_q = 1'b0;

  int checks   = 0;
  int failures = 0;

  ev_t        ev [64];
  int         n_ev = 0;
  int         head [2] = '{0, 0};
  logic [7:0] last_data [2] = '{8'h00, 8'h00};
  logic [7:0] got [2][16];
  int         n_got [2] = '{0, 0};
  int         first_wr [2] = '{-1, -1};

  logic [2:0] k_v;
  ev_t        e_v;
  logic [7:0] exp_d;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  uart_rx_ff #(
    .BAUD_CYCLE(BaudCycle),
    .LSB_FIRST (1'b1)
  ) dut_lsb (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx),
    .i_ff_full  (ff_full),
    .o_wr_en    (wr_en[0]),
    .o_wr_data  (wr_data[0]),
    .o_frame_err(frame_err[0]),
    .o_overrun  (overrun[0])
  );

  uart_rx_ff #(
    .BAUD_CYCLE(BaudCycle),
    .LSB_FIRST (1'b0)
  ) dut_msb (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx),
    .i_ff_full  (ff_full),
    .o_wr_en    (wr_en[1]),
    .o_wr_data  (wr_data[1]),
    .o_frame_err(frame_err[1]),
    .o_overrun  (overrun[1])
  );

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic check(input bit ok, input string name, input int d, input int act,
                       input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s dut%0d: got 0x%0h required 0x%0h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ev(input int c, input logic [2:0] kind, input logic [7:0] data);
    ev[n_ev].cyc  = c;
    ev[n_ev].kind = kind;
    ev[n_ev].data = data;
    n_ev++;
  endtask

  // Start bit, 8 data bits LSB first on the wire, then the stop bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_hi, input bit full);
    int c;
    c = cyc;
    if (!stop_hi)  push_ev(c + Latency, KFe, b);
    else if (full) push_ev(c + Latency, KOv, b);
    else           push_ev(c + Latency, KWr, b);
    rx = 1'b0;
    tick(Bit);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(Bit);
    end
    rx      = stop_hi;
    ff_full = full;
    tick(Bit);
    ff_full = 1'b0;
  endtask

  // Every cycle: pulses must match the next predicted event, data must hold otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int d = 0; d < 2; d++) begin
          k_v = {overrun[d], frame_err[d], wr_en[d]};
          if (rst_q) begin
            check(k_v == 3'b000, "reset_pulses", d, 32'(k_v), 0);
            check(wr_data[d] == 8'h00, "reset_data", d, 32'(wr_data[d]), 0);
            last_data[d] = 8'h00;
          end else if (k_v != 3'b000) begin
            if (head[d] < n_ev) begin
              e_v = ev[head[d]];
              head[d]++;
              exp_d = (d == 0) ? e_v.data : rev8(e_v.data);
              check(k_v == e_v.kind, "pulse_kind", d, 32'(k_v), 32'(e_v.kind));
              check(cyc >= e_v.cyc - 1 && cyc <= e_v.cyc + 1, "pulse_time", d, cyc, e_v.cyc);
              if (e_v.kind == KWr) begin
                check(wr_data[d] == exp_d, "wr_data", d, 32'(wr_data[d]), 32'(exp_d));
                last_data[d] = exp_d;
              end
            end else begin
              check(k_v == 3'b000, "unexpected_pulse", d, 32'(k_v), 0);
            end
            if (wr_en[d] && n_got[d] < 16) begin
              got[d][n_got[d]] = wr_data[d];
              n_got[d]++;
              if (first_wr[d] < 0) first_wr[d] = cyc;
            end
          end else begin
            check(wr_data[d] == last_data[d], "data_hold", d, 32'(wr_data[d]),
                  32'(last_data[d]));
            if (head[d] < n_ev && cyc > ev[head[d]].cyc + 1) begin
              check(k_v != 3'b000, "missing_pulse", d, 32'(k_v), 32'(ev[head[d]].kind));
              head[d]++;
            end
          end
        end
      end
    end
  end

  logic [7:0] exp_lsb [9] = '{8'hA5, 8'h00, 8'hFF, 8'h5A, 8'h3C, 8'h42, 8'h11, 8'hC3, 8'h01};
  logic [7:0] exp_msb [9] = '{8'hA5, 8'h00, 8'hFF, 8'h5A, 8'h3C, 8'h42, 8'h88, 8'hC3, 8'h80};
  logic [7:0] abort_byte = 8'h5A;
  int         c_a5;

  initial begin
    tick(4);
    rst = 1'b0;
    tick(20);

    c_a5 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(40);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(40);

    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(40);

    send_frame(8'h81, 1'b0, 1'b0);
    tick(100);
    rx = 1'b1;
    tick(40);
    send_frame(8'h42, 1'b1, 1'b0);
    tick(40);

    send_frame(8'h7E, 1'b1, 1'b1);
    send_frame(8'h11, 1'b1, 1'b0);
    tick(40);

    // Abort a frame with reset in the middle of data bit 4 (a high bit).
    rx = 1'b0;
    tick(Bit);
    for (int i = 0; i < 4; i++) begin
      rx = abort_byte[i];
      tick(Bit);
    end
    rx = abort_byte[4];
    tick(Bit / 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rx  = 1'b1;
    tick(200);

    send_frame(8'hC3, 1'b1, 1'b0);
    tick(40);
    send_frame(8'h01, 1'b1, 1'b0);
    tick(200);

    for (int d = 0; d < 2; d++) begin
      check(head[d] == n_ev, "events_consumed", d, head[d], n_ev);
      check(n_got[d] == 9, "wr_count", d, n_got[d], 9);
    end
    for (int i = 0; i < 9; i++) begin
      check(got[0][i] === exp_lsb[i], "byte_lsb_first", 0, 32'(got[0][i]), 32'(exp_lsb[i]));
      check(got[1][i] === exp_msb[i], "byte_msb_first", 1, 32'(got[1][i]), 32'(exp_msb[i]));
    end
    check(first_wr[0] - c_a5 >= 154 && first_wr[0] - c_a5 <= 156, "latency_a5", 0,
          first_wr[0] - c_a5, 155);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
